ddr3_cmd_arbiter: RTL and testbench
===================================

DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
REQ-001 SHALL have parameter DDR_ROW_BITS, default 15, the DDR3 row/address bus width (RSB = DDR_ROW_BITS-1).
REQ-002 SHALL have parameter LOCK_MAX, default 64, the maximum number of consecutive sequenced commands from one requester before its grant is forcibly released.
REQ-003 SHALL have ports `clock`  in  1  (the single clock) and `reset`  in  1  (asynchronous, active-high).
REQ-004 SHALL have, for the config/refresh requester: `cfg_req_i` in 1, `cfg_rdy_o` out 1, `cfg_cmd_i` in 3, `cfg_ba_i` in 3, `cfg_adr_i` in DDR_ROW_BITS.
REQ-005 SHALL have, for the memory-controller FSM requester: `ctl_req_i` in 1, `ctl_seq_i` in 1, `ctl_rdy_o` out 1, `ctl_cmd_i` in 3, `ctl_ba_i` in 3, `ctl_adr_i` in DDR_ROW_BITS.
REQ-006 SHALL have, for the bypass requester: `byp_req_i` in 1, `byp_seq_i` in 1, `byp_rdy_o` out 1, `byp_cmd_i` in 3, `byp_ba_i` in 3, `byp_adr_i` in DDR_ROW_BITS.
REQ-007 SHALL have DDL outputs `ddl_req_o` 1, `ddl_seq_o` 1, `ddl_cmd_o` 3, `ddl_ba_o` 3, `ddl_adr_o` DDR_ROW_BITS, and input `ddl_rdy_i` 1.
REQ-008 SHALL have `gnt_o` out 2, the current owner: 0 none, 1 cfg, 2 ctl, 3 byp.

Function
REQ-009 A command SHALL transfer on a rising clock edge where `ddl_req_o` and `ddl_rdy_i` are both high.
REQ-010 The FSM SHALL have states IDLE, GNT_CFG, GNT_CTL and GNT_BYP, and `gnt_o` SHALL encode the state.
REQ-011 In IDLE, the next state SHALL be GNT_CFG if `cfg_req_i` is high. Otherwise it SHALL be the round-robin winner of ctl/byp; otherwise the FSM SHALL stay in IDLE.
REQ-012 The round-robin pointer SHALL favour the requester not most recently granted, and SHALL update on every grant entry.
REQ-013 In a GNT state, the granted requester's req/seq/cmd/ba/adr SHALL drive the `ddl_*` outputs combinationally, and its `*_rdy_o` SHALL equal `ddl_rdy_i`.
REQ-014 All non-granted `*_rdy_o` outputs SHALL be 0, and in IDLE `ddl_req_o` SHALL be 0 (zero-cycle command pass-through; one cycle of arbitration latency from IDLE).
REQ-015 For cfg, `ddl_seq_o` SHALL be 0.
REQ-016 A lock flag SHALL set on a transfer with seq=1 and clear on a transfer with seq=0.
REQ-017 GNT_CFG SHALL return to IDLE after one transfer.
REQ-018 GNT_CTL and GNT_BYP SHALL return to IDLE:
- after a transfer with seq=0, or
- when req is low and lock is clear.
REQ-019 While lock is set and the owner's req is low, the grant SHALL be held and `ddl_req_o` SHALL be 0 (no interleaving mid-sequence).
REQ-020 A lock counter SHALL count sequenced transfers in the current grant.
REQ-021 On reaching LOCK_MAX, the FSM SHALL force a return to IDLE after the next transfer regardless of seq, and SHALL clear lock.
REQ-022 The counter SHALL saturate and never wrap.
REQ-023 A pending `cfg_req_i` SHALL NOT pre-empt a locked ctl/byp sequence; it SHALL win at the next IDLE.
REQ-024 Simultaneous ctl and byp requests in IDLE SHALL be resolved by the round-robin pointer only.
REQ-025 A transfer and a new request in the same cycle SHALL NOT skip IDLE; the FSM SHALL always pass through IDLE for one cycle.

Reset
REQ-026 Asserting `reset` SHALL asynchronously force: state IDLE, `gnt_o`=0, lock=0, lock counter=0, round-robin pointer=ctl-favoured.
REQ-027 During reset, all `*_rdy_o` and `ddl_req_o` SHALL be 0, and `ddl_seq_o`, `ddl_cmd_o`, `ddl_ba_o`, `ddl_adr_o` SHALL be 0.
REQ-028 Reset asserted mid-sequence SHALL abandon the sequence; no partial transfer SHALL be reported.

Structure
REQ-029 State encodings, `gnt_o` codes and DDR3 command encodings SHALL live in the shared DDR3 defines header used by the controller, not be redefined locally.
REQ-030 The block SHALL be a single module with no sub-modules; the output mux and FSM SHALL be in one file.

Verification
REQ-031 cfg and ctl requests in the same IDLE cycle -> GNT_CFG first, one cfg transfer, IDLE for 1 cycle, then GNT_CTL; `gnt_o` sequence 0,1,0,2.
REQ-032 ctl issues ACT(seq=1), RD(seq=1), RD(seq=0) while byp requests continuously -> all three ctl commands reach the DDL contiguously, with no byp command in between; byp is granted next.
REQ-033 ctl and byp both request continuously with single seq=0 commands -> grants alternate 2,3,2,3.
REQ-034 ctl locked, ctl_req low for 5 cycles -> `gnt_o` stays 2, `ddl_req_o`=0, `byp_rdy_o`=0 throughout.
REQ-035 LOCK_MAX=4, byp sends 10 commands all seq=1 -> release after the 5th transfer, ctl granted if pending.
REQ-036 reset pulsed while in GNT_BYP with `ddl_rdy_i`=0 -> outputs zero immediately (asynchronously), state IDLE, no transfer counted.

Source files
------------

// File: rtl/ddr3_cmd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ddr3_cmd_arbiter_pkg
// Shared DDR3 definitions for the controller. The DDL command arbiter takes its
// state encodings, grant codes, command encodings and round-robin helper from
// here.
//   arb_state_e : arbiter FSM state. Its numeric value is the gnt_o code.
//   GNT_*       : grant codes (0 none, 1 cfg, 2 ctl, 3 byp).
//   CMD_*       : DDR3 command encodings {RAS#, CAS#, WE#}.
//   rr_pick     : ctl/byp round-robin choice.
// -----------------------------------------------------------------------------
package ddr3_cmd_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GNT_CFG = 2'd1,
      ST_GNT_CTL = 2'd2,
      ST_GNT_BYP = 2'd3
   } arb_state_e;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_CFG  = 2'd1;
   localparam logic [1:0] GNT_CTL  = 2'd2;
   localparam logic [1:0] GNT_BYP  = 2'd3;

   localparam logic [2:0] CMD_MRS = 3'b000;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_ZQC = 3'b110;
   localparam logic [2:0] CMD_NOP = 3'b111;

   // Round-robin pointer values: which of ctl/byp wins a tie.
   localparam logic RR_FAVOUR_CTL = 1'b0;
   localparam logic RR_FAVOUR_BYP = 1'b1;

   // A tie goes to the favoured requester. A single request always wins.
   function automatic arb_state_e rr_pick(logic favour, logic ctl_req, logic byp_req);
      if (ctl_req && byp_req) return (favour == RR_FAVOUR_BYP) ? ST_GNT_BYP : ST_GNT_CTL;
      if (ctl_req)            return ST_GNT_CTL;
      if (byp_req)            return ST_GNT_BYP;
      return ST_IDLE;
   endfunction

endpackage

// File: rtl/ddr3_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// ddr3_cmd_arbiter
// Arbitrates three command sources onto the single DDL command port.
//   clock, reset          : clock and asynchronous active-high reset
//   cfg_*                 : config/refresh requester (highest priority, one
//                           command per grant, never sequenced)
//   ctl_*                 : memory-controller FSM requester (may sequence)
//   byp_*                 : bypass requester (may sequence)
//   ddl_req_o/seq/cmd/ba/adr, ddl_rdy_i : downstream command handshake
//   gnt_o                 : current owner (0 none, 1 cfg, 2 ctl, 3 byp)
// The owner's command passes to the DDL combinationally. Leaving IDLE costs one
// cycle of arbitration. Every grant returns through IDLE.
// A sequenced owner (seq=1) keeps the grant, even with its req low, until it
// sends seq=0. After LOCK_MAX sequenced transfers, the next transfer always ends
// the grant.
// -----------------------------------------------------------------------------
module ddr3_cmd_arbiter
   import ddr3_cmd_arbiter_pkg::*;
#(
   parameter  int DDR_ROW_BITS = 15,
   parameter  int LOCK_MAX     = 64,
   localparam int RSB          = DDR_ROW_BITS - 1
) (
   input  logic         clock,
   input  logic         reset,

   input  logic         cfg_req_i,
   output logic         cfg_rdy_o,
   input  logic [2:0]   cfg_cmd_i,
   input  logic [2:0]   cfg_ba_i,
   input  logic [RSB:0] cfg_adr_i,

   input  logic         ctl_req_i,
   input  logic         ctl_seq_i,
   output logic         ctl_rdy_o,
   input  logic [2:0]   ctl_cmd_i,
   input  logic [2:0]   ctl_ba_i,
   input  logic [RSB:0] ctl_adr_i,

   input  logic         byp_req_i,
   input  logic         byp_seq_i,
   output logic         byp_rdy_o,
   input  logic [2:0]   byp_cmd_i,
   input  logic [2:0]   byp_ba_i,
   input  logic [RSB:0] byp_adr_i,

   output logic         ddl_req_o,
   output logic         ddl_seq_o,
   output logic [2:0]   ddl_cmd_o,
   output logic [2:0]   ddl_ba_o,
   output logic [RSB:0] ddl_adr_o,
   input  logic         ddl_rdy_i,

   output logic [1:0]   gnt_o
);

   localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

   arb_state_e       state_q, state_d;
   logic             lock_q,  lock_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             rr_q,    rr_d;
   logic             xfer;

   assign xfer  = ddl_req_o & ddl_rdy_i;
   assign gnt_o = state_q;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lock_q  <= 1'b0;
         cnt_q   <= '0;
         rr_q    <= RR_FAVOUR_CTL;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      case (state_q)
         ST_IDLE: begin
            lock_d = 1'b0;
            cnt_d  = '0;
            if (cfg_req_i) begin
               state_d = ST_GNT_CFG;
            end else begin
               state_d = rr_pick(rr_q, ctl_req_i, byp_req_i);
               // The requester just granted loses the next tie.
               if (state_d == ST_GNT_CTL)      rr_d = RR_FAVOUR_BYP;
               else if (state_d == ST_GNT_BYP) rr_d = RR_FAVOUR_CTL;
            end
         end
         ST_GNT_CFG: begin
            if (xfer) state_d = ST_IDLE;
         end
         default: begin
            if (xfer) begin
               if (!ddl_seq_o || cnt_q == CNT_MAX) begin
                  // End of sequence, or the lock budget is used up.
                  state_d = ST_IDLE;
                  lock_d  = 1'b0;
                  cnt_d   = '0;
               end else begin
                  lock_d = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
               end
            end else if (!ddl_req_o && !lock_q) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // Output mux: IDLE drives every output to zero, and so does reset.
   always_comb begin
      ddl_req_o = 1'b0;
      ddl_seq_o = 1'b0;
      ddl_cmd_o = '0;
      ddl_ba_o  = '0;
      ddl_adr_o = '0;
      cfg_rdy_o = 1'b0;
      ctl_rdy_o = 1'b0;
      byp_rdy_o = 1'b0;
      case (state_q)
         ST_GNT_CFG: begin
            ddl_req_o = cfg_req_i;
            ddl_cmd_o = cfg_cmd_i;
            ddl_ba_o  = cfg_ba_i;
            ddl_adr_o = cfg_adr_i;
            cfg_rdy_o = ddl_rdy_i;
         end
         ST_GNT_CTL: begin
            ddl_req_o = ctl_req_i;
            ddl_seq_o = ctl_seq_i;
            ddl_cmd_o = ctl_cmd_i;
            ddl_ba_o  = ctl_ba_i;
            ddl_adr_o = ctl_adr_i;
            ctl_rdy_o = ddl_rdy_i;
         end
         ST_GNT_BYP: begin
            ddl_req_o = byp_req_i;
            ddl_seq_o = byp_seq_i;
            ddl_cmd_o = byp_cmd_i;
            ddl_ba_o  = byp_ba_i;
            ddl_adr_o = byp_adr_i;
            byp_rdy_o = ddl_rdy_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr3_cmd_arbiter
// Each scenario loads per-requester command lists. A transaction-level model
// turns those lists into the expected order of DDL transfers:
//   - pending cfg commands win every arbitration point;
//   - otherwise ctl and byp take turns;
//   - a granted requester sends a burst that ends at seq=0 or after LOCK_MAX+1
//     transfers.
// The expected transfers go into a scoreboard queue. A negedge monitor pops and
// compares one entry for every handshake it sees.
// -----------------------------------------------------------------------------
module tb_ddr3_cmd_arbiter;
   import ddr3_cmd_arbiter_pkg::*;

   localparam int RB   = 15;
   localparam int LMAX = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_req_i = 1'b0, cfg_rdy_o;
   logic [2:0]    cfg_cmd_i = '0, cfg_ba_i = '0;
   logic [RB-1:0] cfg_adr_i = '0;
   logic          ctl_req_i = 1'b0, ctl_seq_i = 1'b0, ctl_rdy_o;
   logic [2:0]    ctl_cmd_i = '0, ctl_ba_i = '0;
   logic [RB-1:0] ctl_adr_i = '0;
   logic          byp_req_i = 1'b0, byp_seq_i = 1'b0, byp_rdy_o;
   logic [2:0]    byp_cmd_i = '0, byp_ba_i = '0;
   logic [RB-1:0] byp_adr_i = '0;
   logic          ddl_req_o, ddl_seq_o, ddl_rdy_i = 1'b0;
   logic [2:0]    ddl_cmd_o, ddl_ba_o;
   logic [RB-1:0] ddl_adr_o;
   logic [1:0]    gnt_o;

   always #5 clock = ~clock;

   ddr3_cmd_arbiter #(.DDR_ROW_BITS(RB), .LOCK_MAX(LMAX)) dut (
      .clock(clock), .reset(reset),
      .cfg_req_i(cfg_req_i), .cfg_rdy_o(cfg_rdy_o), .cfg_cmd_i(cfg_cmd_i),
      .cfg_ba_i(cfg_ba_i), .cfg_adr_i(cfg_adr_i),
      .ctl_req_i(ctl_req_i), .ctl_seq_i(ctl_seq_i), .ctl_rdy_o(ctl_rdy_o),
      .ctl_cmd_i(ctl_cmd_i), .ctl_ba_i(ctl_ba_i), .ctl_adr_i(ctl_adr_i),
      .byp_req_i(byp_req_i), .byp_seq_i(byp_seq_i), .byp_rdy_o(byp_rdy_o),
      .byp_cmd_i(byp_cmd_i), .byp_ba_i(byp_ba_i), .byp_adr_i(byp_adr_i),
      .ddl_req_o(ddl_req_o), .ddl_seq_o(ddl_seq_o), .ddl_cmd_o(ddl_cmd_o),
      .ddl_ba_o(ddl_ba_o), .ddl_adr_o(ddl_adr_o), .ddl_rdy_i(ddl_rdy_i),
      .gnt_o(gnt_o)
   );

   typedef struct packed {
      logic          seq;
      logic [2:0]    cmd;
      logic [2:0]    ba;
      logic [RB-1:0] adr;
   } cmd_t;

   typedef struct packed {
      logic [1:0] gnt;
      logic [2:0] rdy;   // {cfg, ctl, byp}
      cmd_t       c;
   } exp_t;

   cmd_t cfg_l[$], ctl_l[$], byp_l[$];
   bit   ctl_cont[$], byp_cont[$];   // command continues a locked burst
   exp_t expq[$];
   int   total = 0, bad = 0, nxfer = 0;
   int   cfg_after = 0;              // cfg requests only after this many transfers
   int   fixed_gap = -1;             // >=0: fixed req-low gap inside locked bursts
   logic [1:0] prev_gnt = 2'd0;

   function automatic cmd_t mk(logic seq, logic [2:0] cmd);
      cmd_t c;
      c.seq = seq;
      c.cmd = cmd;
      c.ba  = 3'($urandom_range(0, 7));
      c.adr = RB'($urandom);
      return c;
   endfunction

   function automatic int pick_gap();
      if (fixed_gap >= 0) return fixed_gap;
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] need);
      total++;
      if (got !== need) begin
         bad++;
         $display("FAIL %s: got %h, need %h", name, got, need);
      end
   endtask

   task automatic clear_lists();
      cfg_l.delete();
      ctl_l.delete();
      byp_l.delete();
   endtask

   // Reference model: expected transfer order from the command lists alone.
   task automatic build_expect();
      int   ic = 0, it = 0, ib = 0, done = 0, n;
      bit   favour_byp = 1'b0, use_byp, stop;
      exp_t e;
      ctl_cont.delete();
      byp_cont.delete();
      while (ic < cfg_l.size() || it < ctl_l.size() || ib < byp_l.size()) begin
         if (ic < cfg_l.size() && done >= cfg_after) begin
            e.gnt = GNT_CFG; e.rdy = 3'b100; e.c = cfg_l[ic]; e.c.seq = 1'b0;
            expq.push_back(e);
            ic++; done++;
         end else begin
            if (it < ctl_l.size() && ib < byp_l.size()) use_byp = favour_byp;
            else use_byp = (it >= ctl_l.size());
            favour_byp = !use_byp;
            n = 0;
            stop = 1'b0;
            while (!stop) begin
               if (use_byp) begin
                  e.gnt = GNT_BYP; e.rdy = 3'b001; e.c = byp_l[ib];
                  byp_cont.push_back(n > 0);
                  ib++;
                  stop = (ib >= byp_l.size());
               end else begin
                  e.gnt = GNT_CTL; e.rdy = 3'b010; e.c = ctl_l[it];
                  ctl_cont.push_back(n > 0);
                  it++;
                  stop = (it >= ctl_l.size());
               end
               expq.push_back(e);
               n++; done++;
               if (!e.c.seq || n == LMAX + 1) stop = 1'b1;
            end
         end
      end
   endtask

   task automatic present(int ic, int it, int ib, int xfers, int gt, int gb);
      cmd_t c;
      cfg_req_i = (ic < cfg_l.size()) && (xfers >= cfg_after);
      c = '0;
      if (ic < cfg_l.size()) c = cfg_l[ic];
      cfg_cmd_i = c.cmd; cfg_ba_i = c.ba; cfg_adr_i = c.adr;
      ctl_req_i = (it < ctl_l.size()) && (gt == 0);
      c = '0;
      if (it < ctl_l.size()) c = ctl_l[it];
      ctl_seq_i = c.seq; ctl_cmd_i = c.cmd; ctl_ba_i = c.ba; ctl_adr_i = c.adr;
      byp_req_i = (ib < byp_l.size()) && (gb == 0);
      c = '0;
      if (ib < byp_l.size()) c = byp_l[ib];
      byp_seq_i = c.seq; byp_cmd_i = c.cmd; byp_ba_i = c.ba; byp_adr_i = c.adr;
      ddl_rdy_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic run_scenario(string name);
      int ic = 0, it = 0, ib = 0, xfers = 0, gt = 0, gb = 0, cyc = 0;
      bit xc, xt, xb;
      if (cfg_after > ctl_l.size() + byp_l.size()) cfg_after = ctl_l.size() + byp_l.size();
      expq.delete();
      build_expect();
      // Reset with every input active: outputs must stay zero.
      @(posedge clock); #1;
      reset = 1'b1;
      cfg_req_i = 1'b1; ctl_req_i = 1'b1; byp_req_i = 1'b1;
      ctl_seq_i = 1'b1; byp_seq_i = 1'b1; ddl_rdy_i = 1'b1;
      cfg_cmd_i = CMD_REF; ctl_cmd_i = CMD_ACT; byp_cmd_i = CMD_WR;
      cfg_adr_i = '1; ctl_adr_i = '1; byp_adr_i = '1;
      @(posedge clock); #1;
      check({name, " reset_outs"}, {gnt_o, cfg_rdy_o, ctl_rdy_o, byp_rdy_o, ddl_req_o,
            ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o}, 64'd0);
      reset = 1'b0;
      present(0, 0, 0, 0, 0, 0);
      while ((ic < cfg_l.size() || it < ctl_l.size() || ib < byp_l.size()) && cyc < 3000) begin
         @(negedge clock);
         xc = cfg_req_i && cfg_rdy_o;
         xt = ctl_req_i && ctl_rdy_o;
         xb = byp_req_i && byp_rdy_o;
         if (gt > 0)
            check({name, " ctl_lock_hold"}, {gnt_o, ddl_req_o, byp_rdy_o, cfg_rdy_o},
                  {GNT_CTL, 3'b000});
         if (gb > 0)
            check({name, " byp_lock_hold"}, {gnt_o, ddl_req_o, ctl_rdy_o, cfg_rdy_o},
                  {GNT_BYP, 3'b000});
         @(posedge clock); #1;
         cyc++;
         if (gt > 0) gt--;
         if (gb > 0) gb--;
         if (xc) begin ic++; xfers++; end
         if (xt) begin
            it++; xfers++;
            if (it < ctl_l.size() && ctl_cont[it]) gt = pick_gap();
         end
         if (xb) begin
            ib++; xfers++;
            if (ib < byp_l.size() && byp_cont[ib]) gb = pick_gap();
         end
         present(ic, it, ib, xfers, gt, gb);
      end
      if (cyc >= 3000) begin
         total++; bad++;
         $display("FAIL %s timeout: got %0d transfers, need %0d", name, xfers,
                  cfg_l.size() + ctl_l.size() + byp_l.size());
      end
      cfg_req_i = 1'b0; ctl_req_i = 1'b0; byp_req_i = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check({name, " leftover_expected"}, expq.size(), 0);
   endtask

   // Reset while byp holds the grant with the DDL stalled.
   task automatic reset_mid_grant();
      int n0, i;
      clear_lists();
      expq.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      cfg_req_i = 1'b0; ctl_req_i = 1'b0; byp_req_i = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      byp_req_i = 1'b1; byp_seq_i = 1'b1; byp_cmd_i = CMD_ACT;
      byp_ba_i = 3'd5; byp_adr_i = RB'(16'h1234);
      ddl_rdy_i = 1'b0;
      n0 = nxfer;
      i = 0;
      while (gnt_o != GNT_BYP && i < 10) begin
         @(posedge clock); #1;
         i++;
      end
      check("byp_granted_stalled", {gnt_o, ddl_req_o, byp_rdy_o}, {GNT_BYP, 2'b10});
      #1 reset = 1'b1;
      #1;
      check("async_reset_outs", {gnt_o, cfg_rdy_o, ctl_rdy_o, byp_rdy_o, ddl_req_o,
            ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      byp_req_i = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_no_xfer", nxfer - n0, 0);
   endtask

   // Scoreboard monitor, plus a check that every grant change passes through IDLE.
   always @(negedge clock) begin
      exp_t g, e;
      if (ddl_req_o && ddl_rdy_i) begin
         nxfer++;
         total++;
         g.gnt = gnt_o;
         g.rdy = {cfg_rdy_o, ctl_rdy_o, byp_rdy_o};
         g.c.seq = ddl_seq_o; g.c.cmd = ddl_cmd_o; g.c.ba = ddl_ba_o; g.c.adr = ddl_adr_o;
         if (expq.size() == 0) begin
            bad++;
            $display("FAIL xfer_unexpected: got gnt=%0d cmd=%0d adr=%h, need no transfer",
                     g.gnt, g.c.cmd, g.c.adr);
         end else begin
            e = expq.pop_front();
            if (g !== e) begin
               bad++;
               $display("FAIL xfer#%0d: got gnt=%0d rdy=%b seq=%0d cmd=%0d ba=%0d adr=%h, need gnt=%0d rdy=%b seq=%0d cmd=%0d ba=%0d adr=%h",
                        nxfer, g.gnt, g.rdy, g.c.seq, g.c.cmd, g.c.ba, g.c.adr,
                        e.gnt, e.rdy, e.c.seq, e.c.cmd, e.c.ba, e.c.adr);
            end
         end
      end
      if (!reset && gnt_o != prev_gnt) begin
         total++;
         if (prev_gnt != GNT_NONE && gnt_o != GNT_NONE) begin
            bad++;
            $display("FAIL gnt_via_idle: got %0d->%0d, need an IDLE cycle between", prev_gnt, gnt_o);
         end
      end
      prev_gnt = gnt_o;
   end

   initial begin
      int nc, nt, nb;
      fixed_gap = -1;

      // cfg and ctl requesting together: cfg first, then ctl
      clear_lists(); cfg_after = 0;
      cfg_l.push_back(mk(1'b0, CMD_REF));
      ctl_l.push_back(mk(1'b0, CMD_ACT));
      run_scenario("cfg_then_ctl");

      // ctl ACT/RD/RD sequence stays contiguous against a continuous byp request
      clear_lists(); cfg_after = 0;
      ctl_l.push_back(mk(1'b1, CMD_ACT));
      ctl_l.push_back(mk(1'b1, CMD_RD));
      ctl_l.push_back(mk(1'b0, CMD_RD));
      byp_l.push_back(mk(1'b0, CMD_WR));
      byp_l.push_back(mk(1'b0, CMD_WR));
      run_scenario("ctl_sequence");

      // unsequenced ctl and byp alternate
      clear_lists(); cfg_after = 0;
      for (int k = 0; k < 3; k++) begin
         ctl_l.push_back(mk(1'b0, CMD_RD));
         byp_l.push_back(mk(1'b0, CMD_WR));
      end
      run_scenario("alternate");

      // locked ctl drops req for 5 cycles: grant must be held
      clear_lists(); cfg_after = 0; fixed_gap = 5;
      ctl_l.push_back(mk(1'b1, CMD_ACT));
      ctl_l.push_back(mk(1'b0, CMD_RD));
      byp_l.push_back(mk(1'b0, CMD_WR));
      cfg_l.push_back(mk(1'b0, CMD_REF));
      cfg_after = 1;
      run_scenario("lock_hold");
      fixed_gap = -1;

      // byp sends 10 sequenced commands: forced release every LOCK_MAX+1 transfers
      clear_lists(); cfg_after = 0;
      ctl_l.push_back(mk(1'b0, CMD_PRE));
      ctl_l.push_back(mk(1'b0, CMD_PRE));
      for (int k = 0; k < 10; k++) byp_l.push_back(mk(1'b1, CMD_WR));
      run_scenario("lock_max");

      // randomized mixes
      for (int s = 0; s < 12; s++) begin
         clear_lists();
         nc = $urandom_range(0, 2);
         nt = $urandom_range(0, 9);
         nb = $urandom_range(0, 9);
         for (int k = 0; k < nc; k++) cfg_l.push_back(mk(1'b0, 3'($urandom_range(0, 7))));
         for (int k = 0; k < nt; k++)
            ctl_l.push_back(mk((k == nt - 1) ? 1'b0 : 1'($urandom_range(0, 2) != 0),
                               3'($urandom_range(0, 7))));
         for (int k = 0; k < nb; k++)
            byp_l.push_back(mk((k == nb - 1) ? 1'b0 : 1'($urandom_range(0, 2) != 0),
                               3'($urandom_range(0, 7))));
         cfg_after = $urandom_range(0, nt + nb);
         run_scenario("random");
      end

      reset_mid_grant();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
